// File: rtl/w_schedule_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : w_schedule_ctrl_pkg
// Description : Shared constants and state encoding for the message-schedule
//               controller that sequences one w64 instance per 512-bit block.
// Revision    : 1.0 - initial release
// ============================================================================
package w_schedule_ctrl_pkg;

    // Schedule words produced per message block
    localparam int unsigned C_W_LENGTH = 64;
    // Width of a schedule index
    localparam int unsigned C_IDX_W    = $clog2(C_W_LENGTH);

    // Datapath widths
    localparam int unsigned C_BLOCK_W  = 512;   // one message block
    localparam int unsigned C_VEC_W    = 2048;  // full 64-word schedule vector
    localparam int unsigned C_WORD_W   = 32;    // one schedule word

    // Controller states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : w_schedule_ctrl_pkg
`default_nettype wire

// File: rtl/w_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : w_schedule_ctrl
// Description : Accepts one 512-bit block, steps the w64 schedule index
//               0..W_LENGTH-1, closes the w_vector -> prev_w_vector feedback
//               loop and streams W[t] to the round logic under valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module w_schedule_ctrl
    import w_schedule_ctrl_pkg::*;
#(
    parameter int unsigned W_LENGTH = C_W_LENGTH,
    parameter int unsigned IDX_W    = $clog2(W_LENGTH)
) (
    input  logic                 clock,
    input  logic                 reset,

    // Message block source
    input  logic                 msg_valid,
    output logic                 msg_ready,
    input  logic [C_BLOCK_W-1:0] msg_block,
    input  logic                 msg_last,

    // w64 control and data
    output logic                 w_enable,
    output logic [IDX_W-1:0]     w_vector_index,
    output logic                 w_index_complete,
    output logic [C_BLOCK_W-1:0] message_vector,
    output logic [C_VEC_W-1:0]   prev_w_vector,
    input  logic [C_VEC_W-1:0]   w_vector_in,
    input  logic [C_WORD_W-1:0]  cur_w_in,

    // Round-logic word stream
    output logic                 wt_valid,
    input  logic                 wt_ready,
    output logic [C_WORD_W-1:0]  wt_data,
    output logic [IDX_W-1:0]     wt_index,
    output logic                 wt_first_block,
    output logic                 wt_last_block,

    // Status
    output logic                 block_done,
    output logic                 busy
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(W_LENGTH - 1);

    // ------------------------------------------------------------------------
    // State and registered control
    // ------------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_next;
    logic                 r_wt_valid;
    logic                 w_wt_valid_next;
    logic [IDX_W-1:0]     r_wt_index;
    logic [IDX_W-1:0]     w_wt_index_next;
    logic                 r_wic;
    logic                 w_wic_next;
    logic                 r_block_done;
    logic                 w_block_done_next;
    logic                 r_first;
    logic                 w_first_next;
    logic                 r_last;
    logic [C_BLOCK_W-1:0] r_message;

    logic                 w_load;
    logic                 w_advance;
    logic                 w_accept;

    // A new index may be issued whenever the output slot is empty or draining
    assign w_advance = !r_wt_valid || wt_ready;
    assign w_accept  = r_wt_valid && wt_ready;

    // Next-state, issue control and combinational w64 drive
    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_wt_valid_next   = r_wt_valid;
        w_wt_index_next   = r_wt_index;
        w_wic_next        = r_wic;
        w_block_done_next = 1'b0;
        w_first_next      = r_first;
        w_load            = 1'b0;
        msg_ready         = 1'b0;
        w_enable          = 1'b0;
        w_vector_index    = r_idx;
        w_index_complete  = r_wic;

        case (r_state)
            ST_IDLE: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    w_load       = 1'b1;
                    w_idx_next   = '0;
                    w_state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                w_enable = 1'b1;
                if (w_advance) begin
                    w_vector_index  = r_idx;
                    w_wt_valid_next = 1'b1;
                    w_wt_index_next = r_idx;
                    if (r_idx == C_LAST_IDX) begin
                        w_index_complete = 1'b1;
                        w_wic_next       = 1'b1;
                        w_state_next     = ST_FLUSH;
                    end else begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end else begin
                    // Stalled: re-issue the word being presented so w64 keeps
                    // cur_w (and therefore wt_data) on the held word.
                    w_vector_index = r_wt_index;
                end
            end

            ST_FLUSH: begin
                // No new issue; keep re-emitting the final word until taken
                w_enable       = 1'b1;
                w_vector_index = r_wt_index;
                if (w_accept) begin
                    w_wt_valid_next   = 1'b0;
                    w_block_done_next = 1'b1;
                    w_state_next      = ST_DONE;
                end
            end

            ST_DONE: begin
                // Drop index_complete here so IDLE always presents it low
                w_first_next = r_last;
                w_wic_next   = 1'b0;
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register and registered control outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_wt_valid   <= 1'b0;
            r_wt_index   <= '0;
            r_wic        <= 1'b0;
            r_block_done <= 1'b0;
            r_first      <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_wt_valid   <= w_wt_valid_next;
            r_wt_index   <= w_wt_index_next;
            r_wic        <= w_wic_next;
            r_block_done <= w_block_done_next;
            r_first      <= w_first_next;
        end
    end

    // Block latch: message words and last-of-message flag held for the block
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_message <= '0;
            r_last    <= 1'b0;
        end else if (w_load) begin
            r_message <= msg_block;
            r_last    <= msg_last;
        end
    end

    // ------------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------------
    assign message_vector = r_message;
    assign prev_w_vector  = w_vector_in;
    assign wt_data        = cur_w_in;
    assign wt_valid       = r_wt_valid;
    assign wt_index       = r_wt_index;
    assign wt_first_block = r_first;
    assign wt_last_block  = r_last;
    assign block_done     = r_block_done;
    assign busy           = (r_state != ST_IDLE);

endmodule : w_schedule_ctrl
`default_nettype wire

// File: tb/tb_w_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_w_schedule_ctrl
// Description : Self-checking bench for w_schedule_ctrl with a behavioural
//               w64 schedule model and a reference SHA-256 expansion feeding
//               a word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_w_schedule_ctrl;
    import w_schedule_ctrl_pkg::*;

    localparam int unsigned IDX_W = C_IDX_W;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 msg_valid = 1'b0;
    logic                 msg_ready;
    logic [C_BLOCK_W-1:0] msg_block = '0;
    logic                 msg_last = 1'b0;
    logic                 w_enable;
    logic [IDX_W-1:0]     w_vector_index;
    logic                 w_index_complete;
    logic [C_BLOCK_W-1:0] message_vector;
    logic [C_VEC_W-1:0]   prev_w_vector;
    logic [C_VEC_W-1:0]   w_vector_in;
    logic [C_WORD_W-1:0]  cur_w_in;
    logic                 wt_valid;
    logic                 wt_ready = 1'b0;
    logic [C_WORD_W-1:0]  wt_data;
    logic [IDX_W-1:0]     wt_index;
    logic                 wt_first_block;
    logic                 wt_last_block;
    logic                 block_done;
    logic                 busy;

    always #5 clock = ~clock;

    w_schedule_ctrl #(.W_LENGTH(C_W_LENGTH)) u_dut (
        .clock            (clock),
        .reset            (reset),
        .msg_valid        (msg_valid),
        .msg_ready        (msg_ready),
        .msg_block        (msg_block),
        .msg_last         (msg_last),
        .w_enable         (w_enable),
        .w_vector_index   (w_vector_index),
        .w_index_complete (w_index_complete),
        .message_vector   (message_vector),
        .prev_w_vector    (prev_w_vector),
        .w_vector_in      (w_vector_in),
        .cur_w_in         (cur_w_in),
        .wt_valid         (wt_valid),
        .wt_ready         (wt_ready),
        .wt_data          (wt_data),
        .wt_index         (wt_index),
        .wt_first_block   (wt_first_block),
        .wt_last_block    (wt_last_block),
        .block_done       (block_done),
        .busy             (busy)
    );

    // ------------------------------------------------------------------------
    // SHA-256 helpers
    // ------------------------------------------------------------------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // One w64 step: word t from the message or from the fed-back vector
    function automatic logic [31:0] w64_word(input logic [511:0] m,
                                             input logic [2047:0] p,
                                             input int t);
        if (t < 16)
            return m[511 - 32*t -: 32];
        return sig1(p[32*(t-2) +: 32]) + p[32*(t-7) +: 32]
             + sig0(p[32*(t-15) +: 32]) + p[32*(t-16) +: 32];
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural w64: registered cur_w, vector updated from prev_w_vector
    // ------------------------------------------------------------------------
    logic [2047:0] m_vec;
    logic [31:0]   m_cur;
    assign w_vector_in = m_vec;
    assign cur_w_in    = m_cur;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_vec <= '0;
            m_cur <= '0;
        end else if (!w_enable) begin
            m_vec <= '0;
            m_cur <= '0;
        end else begin
            m_vec <= prev_w_vector;
            m_vec[32*int'(w_vector_index) +: 32] <=
                w64_word(message_vector, prev_w_vector, int'(w_vector_index));
            m_cur <= w64_word(message_vector, prev_w_vector, int'(w_vector_index));
        end
    end

    // ------------------------------------------------------------------------
    // Checking and scoreboard
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_value(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] word;
        logic [5:0]  idx;
        logic        first;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_w[64];
    logic        exp_first = 1'b1;
    time         t_hs = 0;
    bit          lat_chk = 1'b0;
    int          done_cnt = 0;
    int          rmode = 0;        // 0: always ready, 1: toggle
    int          stall_left = 0;   // cycles of forced stall on index 63
    bit          stall_active = 1'b0;

    task automatic build_ref(input logic [511:0] blk);
        for (int t = 0; t < 64; t++) begin
            if (t < 16)
                ref_w[t] = blk[511 - 32*t -: 32];
            else
                ref_w[t] = sig1(ref_w[t-2]) + ref_w[t-7]
                         + sig0(ref_w[t-15]) + ref_w[t-16];
        end
    endtask

    // Present a block, wait for the handshake edge, then queue its words
    task automatic send_block(input logic [511:0] blk, input logic last,
                              input bit lat);
        int   n;
        exp_t e;
        @(posedge clock); #1;
        msg_valid = 1'b1;
        msg_block = blk;
        msg_last  = last;
        n = 0;
        while (!msg_ready && n < 400) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 400) chk_value("hs_timeout", 64'd0, 64'd1);
        @(posedge clock);
        t_hs    = $time;
        lat_chk = lat;
        build_ref(blk);
        for (int t = 0; t < 64; t++) begin
            e.word  = ref_w[t];
            e.idx   = 6'(t);
            e.first = exp_first;
            e.last  = last;
            sb.push_back(e);
        end
        exp_first = last;
        #1;
        msg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((busy || sb.size() != 0) && n < 2000);
        if (n >= 2000) chk_value("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_value({tag, "_msg_ready"}, 64'(msg_ready), 64'd1);
        chk_value({tag, "_first"},     64'(wt_first_block), 64'd1);
        chk_value({tag, "_last"},      64'(wt_last_block), 64'd0);
        chk_value({tag, "_wt_valid"},  64'(wt_valid), 64'd0);
        chk_value({tag, "_wt_index"},  64'(wt_index), 64'd0);
        chk_value({tag, "_busy"},      64'(busy), 64'd0);
        chk_value({tag, "_done"},      64'(block_done), 64'd0);
        chk_value({tag, "_w_enable"},  64'(w_enable), 64'd0);
        chk_value({tag, "_wic"},       64'(w_index_complete), 64'd0);
        chk_value({tag, "_msgvec"},    64'(|message_vector), 64'd0);
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Ready driver: changes wt_ready just after each rising edge
    initial begin
        forever begin
            @(posedge clock); #1;
            if (stall_left > 0 && wt_valid && wt_index == 6'd63) begin
                wt_ready     = 1'b0;
                stall_left   = stall_left - 1;
                stall_active = 1'b1;
            end else begin
                stall_active = 1'b0;
                if (rmode == 1) wt_ready = ~wt_ready;
                else            wt_ready = 1'b1;
            end
        end
    end

    // Output monitor: sampled on the falling edge
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                if (wt_valid) begin
                    if (sb.size() == 0) begin
                        chk_value("unexpected_word", 64'(wt_index), 64'd0 - 64'd1);
                    end else begin
                        chk_value("wt_data", 64'(wt_data), 64'(sb[0].word));
                        if (wt_ready) begin
                            chk_value("wt_index", 64'(wt_index), 64'(sb[0].idx));
                            chk_value("wt_first", 64'(wt_first_block), 64'(sb[0].first));
                            chk_value("wt_last",  64'(wt_last_block),  64'(sb[0].last));
                            if (lat_chk && wt_index == 6'd16)
                                chk_value("abc_w16", 64'(wt_data), 64'h61626380);
                            if (lat_chk && wt_index == 6'd63)
                                chk_value("abc_w63", 64'(wt_data), 64'h12B1EDEB);
                            void'(sb.pop_front());
                        end
                    end
                end
                if (stall_active) begin
                    chk_value("stall_wic",   64'(w_index_complete), 64'd1);
                    chk_value("stall_busy",  64'(busy), 64'd1);
                    chk_value("stall_done",  64'(block_done), 64'd0);
                    chk_value("stall_index", 64'(wt_index), 64'd63);
                end
                if (block_done) begin
                    done_cnt++;
                    if (lat_chk)
                        chk_value("done_latency", 64'($time - t_hs), 64'd655);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "simulation timeout");
    end

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    logic [511:0] abc_blk;

    initial begin
        int n;
        abc_blk = {32'h61626380, {14{32'h0}}, 32'h00000018};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_outputs("por");
        @(posedge clock); #1;
        reset = 1'b1;

        // 1: "abc" block, no backpressure, latency of block_done
        rmode = 0;
        send_block(abc_blk, 1'b1, 1'b1);
        wait_idle();
        lat_chk = 1'b0;
        chk_value("t1_done_cnt", 64'(done_cnt), 64'd1);

        // 2: same block with wt_ready toggling every cycle
        rmode = 1;
        send_block(abc_blk, 1'b1, 1'b0);
        wait_idle();
        chk_value("t2_done_cnt", 64'(done_cnt), 64'd2);

        // 3: two blocks back to back, first/last flags
        rmode = 0;
        send_block(rand_blk(), 1'b0, 1'b0);
        send_block(rand_blk(), 1'b1, 1'b0);
        wait_idle();
        chk_value("t3_done_cnt", 64'(done_cnt), 64'd4);

        // 4: hold wt_ready low for 10 cycles on index 63
        stall_left = 10;
        send_block(rand_blk(), 1'b0, 1'b0);
        wait_idle();
        chk_value("t4_stall_used", 64'(stall_left), 64'd0);
        chk_value("t4_done_cnt", 64'(done_cnt), 64'd5);

        // 5: reset at index 30, then a fresh block
        send_block(rand_blk(), 1'b0, 1'b0);
        n = 0;
        while (!(wt_valid && wt_index == 6'd30) && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) chk_value("t5_reach30", 64'd0, 64'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        exp_first = 1'b1;
        @(negedge clock);
        chk_reset_outputs("mid");
        @(posedge clock); #1;
        reset = 1'b1;
        chk_value("t5_no_done", 64'(done_cnt), 64'd5);
        send_block(rand_blk(), 1'b1, 1'b0);
        wait_idle();
        chk_value("t5_done_cnt", 64'(done_cnt), 64'd6);

        // 6: msg_valid pulsed during RUN is ignored
        send_block(rand_blk(), 1'b1, 1'b0);
        repeat (20) @(posedge clock);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            msg_valid = 1'b1;
            msg_block = rand_blk();
            @(negedge clock);
            chk_value("t6_msg_ready", 64'(msg_ready), 64'd0);
        end
        @(posedge clock); #1;
        msg_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clock);
        chk_value("t6_done_cnt", 64'(done_cnt), 64'd7);
        chk_value("t6_idle_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_w_schedule_ctrl
`default_nettype wire
